// File: rtl/ws2812_tx_pkg.sv
// Shared constants for the WS2812 transmitter: FSM state encoding, default
// 50 MHz bit timing, and the GRB field layout used by the colour lookup stage.
package ws2812_tx_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BIT   = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    // Default timing in clk cycles at 50 MHz
    localparam int DEF_T0H_CYC  = 18;     // 0.35 us
    localparam int DEF_T1H_CYC  = 35;     // 0.70 us
    localparam int DEF_TBIT_CYC = 63;     // 1.26 us
    localparam int DEF_TRES_CYC = 15000;  // 300 us

    // Pixel word layout, G first on the wire
    localparam int PIX_W     = 24;
    localparam int GRB_G_MSB = 23;
    localparam int GRB_G_LSB = 16;
    localparam int GRB_R_MSB = 15;
    localparam int GRB_R_LSB = 8;
    localparam int GRB_B_MSB = 7;
    localparam int GRB_B_LSB = 0;

    // Counter width large enough to hold the longer of the bit and latch periods
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b);
    endfunction

endpackage

// File: rtl/ws2812_tx.sv
// WS2812B-style serial transmitter. Accepts one GRB word (or a latch command)
// per valid/ready handshake, shifts the word out MSB-first as pulse-width-coded
// bits on dout, and on command holds dout low for the latch period.
module ws2812_tx
    import ws2812_tx_pkg::*;
#(
    parameter int T0H_CYC    = DEF_T0H_CYC,
    parameter int T1H_CYC    = DEF_T1H_CYC,
    parameter int TBIT_CYC   = DEF_TBIT_CYC,
    parameter int TRES_CYC   = DEF_TRES_CYC,
    parameter int DATA_WIDTH = PIX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  cmd_latch,
    input  logic                  valid,
    output logic                  ready,
    output logic                  dout,
    output logic                  done
);

    localparam int CNT_W = cnt_width(TBIT_CYC, TRES_CYC);

    localparam logic [CNT_W-1:0] T0H       = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0] T1H       = CNT_W'(T1H_CYC);
    localparam logic [CNT_W-1:0] TBIT_LAST = CNT_W'(TBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TRES_LAST = CNT_W'(TRES_CYC - 1);
    localparam logic [4:0]       LAST_BIT  = 5'(DATA_WIDTH - 1);

    // Reject timing that cannot produce distinguishable 0/1 pulses
    if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC && TRES_CYC >= 2)) begin : g_bad_timing
        $error("ws2812_tx: timing parameters out of range");
    end

    // The word layout must match the colour lookup stage's GRB packing
    if (DATA_WIDTH != PIX_W || GRB_G_MSB != DATA_WIDTH - 1 || GRB_G_LSB != GRB_R_MSB + 1 ||
        GRB_R_LSB != GRB_B_MSB + 1 || GRB_B_LSB != 0) begin : g_bad_layout
        $error("ws2812_tx: pixel word layout mismatch");
    end

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cyc_q, cyc_d;
    logic [4:0]            bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  dout_q, dout_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic [CNT_W-1:0]      cyc_inc;
    logic [CNT_W-1:0]      th;

    assign ready   = (state_q == ST_IDLE);
    assign accept  = valid && ready;
    assign cyc_inc = cyc_q + 1'b1;
    // High time of the bit currently on the wire
    assign th      = shift_q[DATA_WIDTH-1] ? T1H : T0H;

    assign dout = dout_q;
    assign done = done_q;

    // Next-state logic; dout_d describes the line level for the cycle cyc_d refers to
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        dout_d    = dout_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dout_d = 1'b0;
                if (accept) begin
                    cyc_d = '0;
                    if (cmd_latch) begin
                        state_d = ST_LATCH;
                    end else begin
                        shift_d   = data;
                        bit_idx_d = '0;
                        dout_d    = 1'b1;
                        state_d   = ST_BIT;
                    end
                end
            end

            ST_BIT: begin
                if (cyc_q == TBIT_LAST) begin
                    cyc_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        // The low tail of the last bit stretches into the idle cycle
                        dout_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
                        bit_idx_d = bit_idx_q + 1'b1;
                        dout_d    = 1'b1;
                    end
                end else begin
                    cyc_d  = cyc_inc;
                    dout_d = (cyc_inc < th);
                end
            end

            ST_LATCH: begin
                dout_d = 1'b0;
                if (cyc_q == TRES_LAST) begin
                    cyc_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cyc_d = cyc_inc;
                end
            end

            default: begin
                cyc_d   = '0;
                dout_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and line state; reset aborts any word or latch in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cyc_q     <= '0;
            bit_idx_q <= '0;
            dout_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_idx_q <= bit_idx_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
        end
    end

    // Pixel shifter; only meaningful while in BIT, so it needs no reset
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_ws2812_tx.sv
// Scoreboard bench for ws2812_tx with shortened timing (T0H=2, T1H=4, TBIT=6, TRES=20).
module tb_ws2812_tx;

    localparam int T0H  = 2;
    localparam int T1H  = 4;
    localparam int TBIT = 6;
    localparam int TRES = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] data;
    logic        cmd_latch;
    logic        valid;
    logic        ready;
    logic        dout;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Expected {dout, ready, done} per cycle following an accept, with a label each
    logic [2:0] exp_q[$];
    string      tag_q[$];

    ws2812_tx #(
        .T0H_CYC   (T0H),
        .T1H_CYC   (T1H),
        .TBIT_CYC  (TBIT),
        .TRES_CYC  (TRES),
        .DATA_WIDTH(24)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .cmd_latch(cmd_latch),
        .valid    (valid),
        .ready    (ready),
        .dout     (dout),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle, pop the expected line state or expect idle
    always @(negedge clk) begin
        logic [2:0] got;
        logic [2:0] want;
        string      what;
        got = {dout, ready, done};
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            what = tag_q.pop_front();
        end else begin
            want = 3'b010;
            what = "idle";
        end
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t {dout,ready,done} got %b expected %b", what, $time, got, want);
        end
    end

    // Offer a word or latch command; once accepted, push the expected response.
    // cut >= 0 truncates the expected stream for a reset after that many cycles.
    task automatic send(input logic [23:0] w, input bit latch, input int cut);
        logic [2:0] tmp[$];
        string      tt[$];
        bit         ok;
        int         n;
        ok = 1'b0;
        @(negedge clk);
        data      = w;
        cmd_latch = latch;
        valid     = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake %06h ready never seen (got 0, expected 1)", w);
            return;
        end
        @(posedge clk);
        if (latch) begin
            for (int c = 0; c < TRES; c++) begin
                tmp.push_back(3'b000);
                tt.push_back($sformatf("latch c%0d", c));
            end
            tmp.push_back(3'b011);
            tt.push_back("latch done");
        end else begin
            for (int b = 23; b >= 0; b--) begin
                for (int c = 0; c < TBIT; c++) begin
                    int th;
                    th = w[b] ? T1H : T0H;
                    tmp.push_back({(c < th) ? 1'b1 : 1'b0, 2'b00});
                    tt.push_back($sformatf("px %06h b%0d c%0d", w, b, c));
                end
            end
            tmp.push_back(3'b010);
            tt.push_back($sformatf("px %06h end", w));
        end
        n = (cut >= 0) ? cut : tmp.size();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(tmp[i]);
            tag_q.push_back(tt[i]);
        end
        if (cut >= 0) begin
            exp_q.push_back(3'b010);
            tag_q.push_back($sformatf("px %06h reset", w));
        end
    endtask

    // Wait for the scoreboard to empty, bounded
    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    initial begin
        reset     = 1'b1;
        valid     = 1'b1;
        data      = 24'hFFFFFF;
        cmd_latch = 1'b0;

        // Reset for 3 cycles with valid high: nothing may be accepted
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        valid = 1'b0;
        repeat (3) @(negedge clk);

        // Single pixel: long first and last bits, short middle bits
        send(24'h800001, 1'b0, -1);
        @(negedge clk);
        valid = 1'b0;
        wait_drain(400);

        // Back-to-back pixels with valid held
        send(24'hFFFFFF, 1'b0, -1);
        send(24'h000000, 1'b0, -1);
        @(negedge clk);
        valid = 1'b0;
        wait_drain(400);

        // Latch command; data must be ignored
        send(24'hFFFFFF, 1'b1, -1);
        @(negedge clk);
        valid = 1'b0;
        wait_drain(400);

        // Reset at cyc=1 of bit 5, then a clean pixel
        send(24'h5A5A5A, 1'b0, 32);
        @(negedge clk);
        valid = 1'b0;
        repeat (31) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_drain(50);
        send(24'hC0FFEE, 1'b0, -1);
        @(negedge clk);
        valid = 1'b0;
        wait_drain(400);

        // Inputs churn while busy; the captured word must be sent unchanged
        send(24'h3CA50F, 1'b0, -1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            data      = 24'($urandom);
            cmd_latch = 1'($urandom_range(0, 1));
            valid     = (i % 5 == 2);
        end
        @(negedge clk);
        valid = 1'b0;
        wait_drain(400);

        // Latch followed immediately by a pixel
        send(24'h000000, 1'b1, -1);
        send(24'h0F0F0F, 1'b0, -1);
        @(negedge clk);
        valid = 1'b0;
        wait_drain(400);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
